primos_seq: RTL and testbench
=============================

Name: primos_seq

Overview:
- Parametrised, sequential successor to the 4-bit combinational prime detector.
- Accepts a WIDTH-bit unsigned number on a start strobe and tests it by trial division, one candidate divisor per clock.
- Reports prime/not-prime with a one-cycle done pulse.
- Sits behind a controller or bench that drives a start/busy/done handshake.

Parameters:
- WIDTH, 8, bit width of the tested number; legal range 4..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request strobe; sampled only while idle.
- numero  input  WIDTH  unsigned number to test; sampled together with start.
- busy  output  1  high while a test is in progress.
- done  output  1  one-cycle pulse when a result is valid.
- es_primo  output  1  result: 1 = prime; held until the next accepted start.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values: busy=0, done=0, es_primo=0; FSM returns to IDLE; internal number and divisor registers cleared.
- State IDLE: busy=0.
  - At a clk edge with start=1, latch numero into n, set d=2, clear es_primo, go to CHECK.
  - busy=1 from the following cycle.
- State CHECK: busy=1; one evaluation per clk edge, in this priority order:
  - 1. n<2: es_primo=0, decide.
  - 2. d*d > n: es_primo=1, decide.
  - 3. n mod d == 0: es_primo=0, decide.
  - 4. Otherwise d=d+1, stay in CHECK.
- Arithmetic widths: d is WIDTH bits; d*d is computed at 2*WIDTH bits with no truncation; n mod d is combinational at WIDTH bits (d is never 0).
- Decide: on the deciding edge, set done=1 and busy=0, and go to DONE.
- State DONE: lasts one cycle, then done=0 and the FSM goes to IDLE. A start during DONE is ignored.
- Latency: k evaluating edges after the accepting edge. done is high in the cycle after the k-th evaluating edge.
  - n=0, 1, 2, 3: k=1.
  - n=97: k=9 (d=2..9 fail, d=10 exceeds the square-root bound).
  - n=91: k=6 (d=7 divides).
- Sequencing: back-to-back start is allowed in the first IDLE cycle after DONE.
- start while busy or in DONE: ignored; numero changes during CHECK have no effect.
- Reset mid-operation: abandon the test immediately; no done pulse; es_primo=0.
- rst and start in the same cycle: rst wins.
- Maximum n = 2^WIDTH-1: the loop must terminate (d never wraps, since d <= 2^(WIDTH/2)+1).

Optional Feature:
- Macro: PRIMOS_FACTOR_EN.
- Defined:
  - Adds output port factor, WIDTH bits.
  - On the deciding edge, factor = d when rule 3 fired (smallest divisor), else 0.
  - Reset value 0; held until the next accepted start, which clears it.
  - Example: n=91 gives factor=7; n=97 gives factor=0.
- Undefined: the port is absent and no extra logic is generated; all other behaviour is identical.

Test Plan:
- Exhaustive, WIDTH=4: start with numero=0..15 sequentially, waiting for done each time -> es_primo=1 exactly for 2, 3, 5, 7, 11, 13; every done is exactly one cycle wide.
- Latency, WIDTH=8: numero=97 -> done 9 cycles after acceptance with es_primo=1; numero=91 -> done after 6 cycles with es_primo=0 (factor=7 with PRIMOS_FACTOR_EN).
- Boundary, WIDTH=8: numero=255 -> es_primo=0 (factor=3); numero=251 -> es_primo=1, done after 15 evaluations (d=2..16); numero=0 and numero=1 -> es_primo=0 after 1 evaluation.
- Handshake: pulse start=1 with numero=4 while busy from a prior numero=97 -> ignored; the result is 97's (es_primo=1); a later start on the first IDLE cycle is accepted.
- Reset mid-op: start numero=251, assert rst on the 5th CHECK cycle -> next cycle busy=0, done=0, es_primo=0; no done pulse follows.
- Simultaneous: rst=1 and start=1 in the same cycle -> remains IDLE with busy=0.

Source files
------------

// File: rtl/primos_seq.sv
// rtl/primos_seq.sv - sequential trial-division prime tester, one candidate divisor per clock.
// Optional PRIMOS_FACTOR_EN adds a 'factor' output holding the smallest divisor found.
module primos_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] numero,
   output logic             busy,
   output logic             done,
`ifdef PRIMOS_FACTOR_EN
   output logic [WIDTH-1:0] factor,
`endif
   output logic             es_primo
);

   typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] n, d;
   logic [WIDTH-1:0] rem;
   logic [2*WIDTH-1:0] d_sq;
   logic             too_small, past_root, divides;

   // Square at full double width so the bound check can never wrap.
   assign d_sq      = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
   assign too_small = n < WIDTH'(2);
   assign past_root = d_sq > {{WIDTH{1'b0}}, n};
   assign divides   = rem == '0;
   assign busy      = state == CHECK;
   assign done      = state == DONE;

   always_comb begin
      rem = n;
      if (d != '0) rem = n % d;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CHECK;
         CHECK:   if (too_small || past_root || divides) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n        <= '0;
         d        <= '0;
         es_primo <= 1'b0;
`ifdef PRIMOS_FACTOR_EN
         factor   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  n        <= numero;
                  d        <= WIDTH'(2);
                  es_primo <= 1'b0;
`ifdef PRIMOS_FACTOR_EN
                  factor   <= '0;
`endif
               end
            end
            CHECK: begin
               // Priority matters: the root bound is tested before divisibility.
               if (too_small) begin
                  es_primo <= 1'b0;
               end else if (past_root) begin
                  es_primo <= 1'b1;
               end else if (divides) begin
                  es_primo <= 1'b0;
`ifdef PRIMOS_FACTOR_EN
                  factor   <= d;
`endif
               end else begin
                  d <= d + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_primos_seq.sv
// tb/tb_primos_seq.sv - self-checking bench for primos_seq (WIDTH=8 main instance, WIDTH=4 exhaustive instance).
module tb_primos_seq;

   logic       clk = 1'b0;
   logic       rst, start, start4;
   logic [7:0] numero;
   logic [3:0] numero4;
   logic       busy, done, es_primo;
   logic       busy4, done4, es_primo4;
`ifdef PRIMOS_FACTOR_EN
   logic [7:0] factor;
   logic [3:0] factor4;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   primos_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .numero(numero),
      .busy(busy), .done(done),
`ifdef PRIMOS_FACTOR_EN
      .factor(factor),
`endif
      .es_primo(es_primo)
   );

   primos_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .numero(numero4),
      .busy(busy4), .done(done4),
`ifdef PRIMOS_FACTOR_EN
      .factor(factor4),
`endif
      .es_primo(es_primo4)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference results from plain trial division.
   function automatic bit ref_prime(int v);
      if (v < 2) return 1'b0;
      for (int q = 2; q * q <= v; q++) if (v % q == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int ref_evals(int v);
      if (v < 2) return 1;
      for (int q = 2; q <= v; q++) if (q * q > v || v % q == 0) return q - 1;
      return 1;
   endfunction

   function automatic int ref_factor(int v);
      if (v < 2) return 0;
      for (int q = 2; q * q <= v; q++) if (v % q == 0) return q;
      return 0;
   endfunction

   // Cycle-level expectation for the WIDTH=8 instance.
   bit m_busy = 0, m_done = 0, m_prime = 0, p_prime = 0;
   int m_cnt = 0, m_factor = 0, p_factor = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 0; m_done <= 0; m_prime <= 0; m_factor <= 0; m_cnt <= 0;
      end else if (m_done) begin
         m_done <= 0;
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy <= 0; m_done <= 1; m_prime <= p_prime; m_factor <= p_factor;
         end
      end else if (start) begin
         m_busy   <= 1;
         m_prime  <= 0;
         m_factor <= 0;
         m_cnt    <= ref_evals(int'(numero));
         p_prime  <= ref_prime(int'(numero));
         p_factor <= ref_factor(int'(numero));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", 32'(busy), 32'(m_busy));
         check("cyc_done", 32'(done), 32'(m_done));
         check("cyc_es_primo", 32'(es_primo), 32'(m_prime));
`ifdef PRIMOS_FACTOR_EN
         check("cyc_factor", 32'(factor), 32'(m_factor));
`endif
      end
   end

   // Start a test on the main instance and check latency and result against hand values.
   task automatic run(input int v, input bit exp_p, input int exp_k, input int exp_f, input bit poke);
      int lat = 0;
      start = 1'b1; numero = 8'(v);
      @(negedge clk);
      start = 1'b0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
         if (poke && lat == 3 && !done) begin start = 1'b1; numero = 8'd4; end
         else start = 1'b0;
      end
      check($sformatf("lat_%0d", v), 32'(lat), 32'(exp_k));
      check($sformatf("prime_%0d", v), 32'(es_primo), 32'(exp_p));
`ifdef PRIMOS_FACTOR_EN
      check($sformatf("factor_%0d", v), 32'(factor), 32'(exp_f));
`endif
      if (poke) begin start = 1'b1; numero = 8'd3; end
      @(negedge clk);
      start = 1'b0;
      check($sformatf("done_width_%0d", v), 32'(done), 32'd0);
      check($sformatf("held_%0d", v), 32'(es_primo), 32'(exp_p));
   endtask

   task automatic run4(input int v, input bit exp_p);
      int lat = 0;
      start4 = 1'b1; numero4 = 4'(v);
      @(negedge clk);
      start4 = 1'b0;
      while (!done4 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("w4_done_%0d", v), 32'(done4), 32'd1);
      check($sformatf("w4_prime_%0d", v), 32'(es_primo4), 32'(exp_p));
      @(negedge clk);
      check($sformatf("w4_width_%0d", v), 32'(done4), 32'd0);
   endtask

   initial begin
      logic [15:0] mask;
      int          seen;
      mask = 16'h28AC;
      rst = 1'b1; start = 1'b0; start4 = 1'b0; numero = '0; numero4 = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_es_primo", 32'(es_primo), 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      run(97, 1, 9, 0, 0);
      run(91, 0, 6, 7, 0);
      run(255, 0, 2, 3, 0);
      run(251, 1, 15, 0, 0);
      run(0, 0, 1, 0, 0);
      run(1, 0, 1, 0, 0);
      run(2, 1, 1, 0, 0);
      run(97, 1, 9, 0, 1);
      run(4, 0, 1, 2, 0);

      for (int i = 0; i < 16; i++) run4(i, mask[i]);

      // Reset on the 5th CHECK cycle of 251.
      start = 1'b1; numero = 8'd251;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_es_primo", 32'(es_primo), 32'd0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("mid_no_done", 32'(seen), 32'd0);

      rst = 1'b1; start = 1'b1; numero = 8'd7;
      @(negedge clk);
      check("sim_busy", 32'(busy), 32'd0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("sim_idle", 32'(busy), 32'd0);

      run(13, 1, 3, 0, 0);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
